// File: rtl/rob_alloc_ctrl_if.sv
// Purpose : decoder/commit-facing signal bundle of the ROB allocator.
// Latency : n/a (wires only).
// Backpressure: alloc_ready gates the decoder; retire side has no backpressure.
interface rob_alloc_ctrl_if #(
    parameter int WIDTH = 4,
    parameter int IDX_W = 5,
    parameter int RC_W  = 3
);
    logic                     alloc_valid;
    logic                     alloc_ready;
    logic [WIDTH*IDX_W-1:0]   alloc_entries;
    logic [RC_W-1:0]          retire_count;
    logic                     flush;
    logic [IDX_W:0]           free_count;
    logic [IDX_W-1:0]         oldest_idx;
    logic                     rob_empty;
    logic                     err_underflow;
    logic [15:0]              stall_cycles;

    // Driver side: decoder plus commit logic.
    modport master (
        output alloc_valid, retire_count, flush,
        input  alloc_ready, alloc_entries, free_count, oldest_idx,
               rob_empty, err_underflow, stall_cycles
    );

    // Allocator side.
    modport slave (
        input  alloc_valid, retire_count, flush,
        output alloc_ready, alloc_entries, free_count, oldest_idx,
               rob_empty, err_underflow, stall_cycles
    );
endinterface

// File: rtl/rob_alloc_ctrl.sv
// Purpose : circular in-order ROB entry allocator/recycler (optional stall counter: ROB_ALLOC_STATS_EN).
// Latency : grants/retires applied at the clock edge, visible next cycle; alloc_entries combinational from head.
// Backpressure: alloc_ready drops when fewer than WIDTH entries are free or while flushing; no partial bundles.
module rob_alloc_ctrl #(
    parameter int WIDTH     = 4,
    parameter int ROB_DEPTH = 32,
    parameter int IDX_W     = $clog2(ROB_DEPTH),
    parameter int RET_W     = 4,
    parameter int RC_W      = $clog2(RET_W + 1)
) (
    input  logic             clk,
    input  logic             rst,
    rob_alloc_ctrl_if.slave  bus
);
    localparam int PTR_W = IDX_W + 1;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_FLUSH = 1'b1
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [PTR_W-1:0]       r_head;
    logic [PTR_W-1:0]       r_tail;
    logic [PTR_W-1:0]       w_head_nxt;
    logic [PTR_W-1:0]       w_tail_nxt;
    logic [PTR_W-1:0]       w_occ;
    logic [PTR_W-1:0]       w_free;
    logic [PTR_W-1:0]       w_ret;
    logic                   r_err;
    logic                   w_err_nxt;
    logic                   w_ready;
    logic                   w_fire;
    logic [WIDTH*IDX_W-1:0] w_entries;

    // Wrap bit in the pointer MSB makes head-tail the true occupancy even when full.
    assign w_occ   = r_head - r_tail;
    assign w_free  = PTR_W'(ROB_DEPTH) - w_occ;
    assign w_ready = (r_state == ST_RUN) && (w_free >= PTR_W'(WIDTH));
    assign w_fire  = bus.alloc_valid & w_ready;
    assign w_ret   = PTR_W'(bus.retire_count);

    // Next state and pointers; flush overrides any alloc/retire in the same cycle.
    always_comb begin
        w_state_nxt = r_state;
        w_head_nxt  = r_head;
        w_tail_nxt  = r_tail;
        w_err_nxt   = r_err;
        case (r_state)
            ST_RUN: begin
                if (bus.flush) begin
                    w_state_nxt = ST_FLUSH;
                    w_head_nxt  = '0;
                    w_tail_nxt  = '0;
                end else begin
                    // Over-retire clamps to the current occupancy and is flagged.
                    if (w_ret > w_occ) begin
                        w_tail_nxt = r_head;
                        w_err_nxt  = 1'b1;
                    end else begin
                        w_tail_nxt = r_tail + w_ret;
                    end
                    if (w_fire) begin
                        w_head_nxt = r_head + PTR_W'(WIDTH);
                    end
                end
            end
            ST_FLUSH: begin
                w_head_nxt = '0;
                w_tail_nxt = '0;
                if (!bus.flush) begin
                    w_state_nxt = ST_RUN;
                end
            end
            default: begin
                w_state_nxt = ST_RUN;
            end
        endcase
    end

    // State, pointer and sticky error registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_RUN;
            r_head  <= '0;
            r_tail  <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_head  <= w_head_nxt;
            r_tail  <= w_tail_nxt;
            r_err   <= w_err_nxt;
        end
    end

    // Lane i offers (head+i) mod ROB_DEPTH; truncation to IDX_W does the wrap.
    always_comb begin
        w_entries = '0;
        for (int i = 0; i < WIDTH; i++) begin
            w_entries[IDX_W*i +: IDX_W] = r_head[IDX_W-1:0] + IDX_W'(i);
        end
    end

`ifdef ROB_ALLOC_STATS_EN
    logic [15:0] r_stall;

    // Saturating count of cycles the decoder offered a bundle that was refused.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_stall <= '0;
        end else if (bus.alloc_valid && !w_ready && (r_stall != 16'hFFFF)) begin
            r_stall <= r_stall + 16'd1;
        end
    end

    assign bus.stall_cycles = r_stall;
`else
    assign bus.stall_cycles = 16'h0;
`endif

    assign bus.alloc_ready   = w_ready;
    assign bus.alloc_entries = w_entries;
    assign bus.free_count    = w_free;
    assign bus.oldest_idx    = r_tail[IDX_W-1:0];
    assign bus.rob_empty     = (w_occ == '0);
    assign bus.err_underflow = r_err;
endmodule
